universal_shift: RTL and testbench
==================================

UNIVERSAL_SHIFT -- requirements
Module: universal_shift

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits (>= 2).
REQ-002 Parameter: AMT_W, default $clog2(WIDTH), width of the shift-amount field.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: load  input  1  parallel load request.
REQ-006 Port: din  input  WIDTH  parallel load data.
REQ-007 Port: start  input  1  shift-operation request.
REQ-008 Port: mode  input  3  operation code, sampled with start.
REQ-009 Port: amount  input  AMT_W  number of one-bit steps, sampled with start.
REQ-010 Port: ser_in  input  1  fill bit for logical shifts, sampled every shift cycle.
REQ-011 Port: dout  output  WIDTH  register contents, registered.
REQ-012 Port: ser_out  output  1  bit most recently shifted or rotated out, registered.
REQ-013 Port: busy  output  1  high while in SHIFT state.
REQ-014 Port: done  output  1  one-cycle completion pulse, registered.

Function
REQ-015 Mode codes: 0 logical left, 1 logical right, 2 arithmetic right, 3 rotate left, 4 rotate right, 5-7 reserved.
REQ-016 One step per cycle:
- logical left: ser_in enters bit 0; bit WIDTH-1 goes to ser_out.
- logical right: ser_in enters bit WIDTH-1; bit 0 goes to ser_out.
- arithmetic right: bit WIDTH-1 is replicated; bit 0 goes to ser_out.
- rotates: the bit leaving the register enters the opposite end and is also copied to ser_out.
REQ-017 Reserved modes run the full step count with dout and ser_out held.
REQ-018 FSM states are IDLE and SHIFT; a down-counter cnt (AMT_W bits) holds the remaining steps, and mode is latched into an internal register.
REQ-019 IDLE, load=1: dout<=din, ser_out<=0; remain in IDLE; start in the same cycle is ignored.
REQ-020 IDLE, load=0, start=1, amount=N>0: latch mode, cnt<=N, go to SHIFT; dout unchanged that edge.
REQ-021 IDLE, start=1, amount=0: stay IDLE, dout unchanged, done=1 on the next cycle.
REQ-022 SHIFT, each edge: perform one step and decrement cnt; on the edge where cnt==1, return to IDLE and set done=1 for exactly one cycle.
REQ-023 For start sampled at edge E0 with amount N>0: steps occur at E1..EN, busy is high from after E0 until EN, the final dout is visible after EN, and done is high for one cycle after EN.
REQ-024 start while busy is ignored; mode, amount and din changes while busy have no effect.
REQ-025 load while busy aborts: dout<=din, ser_out<=0, state->IDLE, cnt<=0, and no done pulse for the aborted operation.
REQ-026 Priority per edge: rst > load > start.
REQ-027 done is 0 in every cycle except the single completion cycle; busy and done are never high together.

Reset
REQ-028 When rst=1 at a clock edge: dout=0, ser_out=0, busy=0, done=0, cnt=0, state=IDLE, latched mode=0.
REQ-029 Reset applied mid-operation discards the operation without a done pulse.

Verification
REQ-030 Assert rst for 2 cycles while load=1 and start=1 -> dout=0x00, busy=0, done=0, ser_out=0.
REQ-031 WIDTH=8: load 0x96; start with mode=2, amount=3 -> busy high for 3 cycles, then dout=0xF2, ser_out=1, done pulses once.
REQ-032 Load 0x0F; mode=0, amount=4, ser_in=1 -> dout=0xFF, ser_out=0. Load 0x81; mode=3, amount=1 -> dout=0x03, ser_out=1.
REQ-033 Load 0x01; mode=4, amount=7 -> dout=0x02 after 7 busy cycles. amount=0 with any mode -> dout unchanged, busy never high, done pulses on the next cycle.
REQ-034 Load 0xF0; mode=1, amount=5; assert load with din=0x55 on the 2nd busy cycle -> dout=0x55, busy=0 on the next cycle, no done pulse.
REQ-035 Assert start again on the 1st busy cycle -> ignored, with a single done pulse at the original completion time; also run a random load/start/mode/amount sequence checked against a reference model.

Source files
------------

// File: rtl/universal_shift.sv
// Universal shift/rotate register: parallel load, then a multi-cycle
// shift of 'amount' single-bit steps in one of five modes.
module universal_shift #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             ser_in,
  output logic [WIDTH-1:0] dout,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_LSR = 3'd1;
  localparam logic [2:0] MODE_ASR = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  state_t           state, state_nxt;
  logic [AMT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       mode_q, mode_nxt;
  logic [WIDTH-1:0] dout_nxt, step_dout;
  logic             ser_out_nxt, step_so, done_nxt;

  // One step of the latched operation; reserved codes leave everything held.
  always_comb begin
    step_dout = dout;
    step_so   = ser_out;
    case (mode_q)
      MODE_LSL: begin
        step_dout = {dout[WIDTH-2:0], ser_in};
        step_so   = dout[WIDTH-1];
      end
      MODE_LSR: begin
        step_dout = {ser_in, dout[WIDTH-1:1]};
        step_so   = dout[0];
      end
      MODE_ASR: begin
        step_dout = {dout[WIDTH-1], dout[WIDTH-1:1]};
        step_so   = dout[0];
      end
      MODE_ROL: begin
        step_dout = {dout[WIDTH-2:0], dout[WIDTH-1]};
        step_so   = dout[WIDTH-1];
      end
      MODE_ROR: begin
        step_dout = {dout[0], dout[WIDTH-1:1]};
        step_so   = dout[0];
      end
      default: begin
        step_dout = dout;
        step_so   = ser_out;
      end
    endcase
  end

  // Next-state logic; load outranks start and also aborts a running shift.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    mode_nxt    = mode_q;
    dout_nxt    = dout;
    ser_out_nxt = ser_out;
    done_nxt    = 1'b0;
    if (load) begin
      dout_nxt    = din;
      ser_out_nxt = 1'b0;
      state_nxt   = IDLE;
      cnt_nxt     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (amount == '0) begin
              done_nxt = 1'b1;
            end else begin
              mode_nxt  = mode;
              cnt_nxt   = amount;
              state_nxt = SHIFT;
            end
          end
        end
        SHIFT: begin
          dout_nxt    = step_dout;
          ser_out_nxt = step_so;
          cnt_nxt     = cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mode_q  <= '0;
      dout    <= '0;
      ser_out <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mode_q  <= mode_nxt;
      dout    <= dout_nxt;
      ser_out <= ser_out_nxt;
      done    <= done_nxt;
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_universal_shift.sv
// Directed-vector and reference-model bench for universal_shift (WIDTH=8).
module tb_universal_shift;

  logic       clk = 1'b0;
  logic       rst, load, start, ser_in;
  logic [7:0] din;
  logic [2:0] mode, amount;
  logic [7:0] dout;
  logic       ser_out, busy, done;

  int checks = 0;
  int errors = 0;

  universal_shift #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .load(load), .din(din), .start(start),
    .mode(mode), .amount(amount), .ser_in(ser_in),
    .dout(dout), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [2:0] mode;
    logic [2:0] amount;
    logic       ser_in;
    logic [7:0] exp_dout;
    logic       exp_so;
  } vec_t;

  vec_t vecs[10];

  task automatic applyStimulus(input logic r, input logic ld, input logic [7:0] d,
                               input logic st, input logic [2:0] md,
                               input logic [2:0] amt, input logic si);
    rst = r; load = ld; din = d; start = st; mode = md; amount = amt; ser_in = si;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [8:0] model_step(input logic [7:0] d, input logic [2:0] md,
                                            input logic si, input logic so);
    case (md)
      3'd0: return {d[7], (d << 1) | {7'd0, si}};
      3'd1: return {d[0], (d >> 1) | {si, 7'd0}};
      3'd2: return {d[0], 8'($signed(d) >>> 1)};
      3'd3: return {d[7], (d << 1) | (d >> 7)};
      3'd4: return {d[0], (d >> 1) | (d << 7)};
      default: return {so, d};
    endcase
  endfunction

  // Load, start, then follow busy until it drops, checking the result and done.
  task automatic runVector(input int idx, input vec_t v);
    int busy_cycles;
    applyStimulus(0, 1, v.din, 0, 0, 0, v.ser_in);
    checkOutput($sformatf("v%0d load dout", idx), dout, v.din);
    applyStimulus(0, 0, 8'h00, 1, v.mode, v.amount, v.ser_in);
    start = 0;
    busy_cycles = 0;
    while (busy && busy_cycles < 20) begin
      busy_cycles++;
      if (done) checkOutput($sformatf("v%0d done while busy", idx), done, 0);
      applyStimulus(0, 0, 8'h00, 0, 3'd7, 3'd7, v.ser_in);
    end
    checkOutput($sformatf("v%0d busy cycles", idx), busy_cycles, v.amount);
    checkOutput($sformatf("v%0d done", idx), done, 1);
    checkOutput($sformatf("v%0d dout", idx), dout, v.exp_dout);
    checkOutput($sformatf("v%0d ser_out", idx), ser_out, v.exp_so);
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
    checkOutput($sformatf("v%0d done drop", idx), done, 0);
    checkOutput($sformatf("v%0d dout hold", idx), dout, v.exp_dout);
  endtask

  initial begin
    int bc, dc;
    logic [7:0] m_dout;
    logic       m_so, m_busy, m_done;
    logic [2:0] m_cnt, m_mode;
    logic [8:0] st9;
    logic       r, ld, st, si;
    logic [7:0] d;
    logic [2:0] md, amt;

    vecs[0] = '{8'h96, 3'd2, 3'd3, 1'b0, 8'hF2, 1'b1};
    vecs[1] = '{8'h0F, 3'd0, 3'd4, 1'b1, 8'hFF, 1'b0};
    vecs[2] = '{8'h81, 3'd3, 3'd1, 1'b0, 8'h03, 1'b1};
    vecs[3] = '{8'h01, 3'd4, 3'd7, 1'b0, 8'h02, 1'b0};
    vecs[4] = '{8'hA5, 3'd1, 3'd2, 1'b0, 8'h29, 1'b0};
    vecs[5] = '{8'h3C, 3'd5, 3'd3, 1'b1, 8'h3C, 1'b0};
    vecs[6] = '{8'h5A, 3'd2, 3'd0, 1'b1, 8'h5A, 1'b0};
    vecs[7] = '{8'hC3, 3'd1, 3'd1, 1'b1, 8'hE1, 1'b1};
    vecs[8] = '{8'h7F, 3'd2, 3'd7, 1'b0, 8'h00, 1'b1};
    vecs[9] = '{8'h80, 3'd2, 3'd7, 1'b0, 8'hFF, 1'b0};

    // Reset held two cycles with load and start also asserted.
    applyStimulus(1, 1, 8'hFF, 1, 3'd0, 3'd3, 1);
    applyStimulus(1, 1, 8'hFF, 1, 3'd0, 3'd3, 1);
    checkOutput("reset dout", dout, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset ser_out", ser_out, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) runVector(i, vecs[i]);

    // Load on the second busy cycle aborts without a done pulse.
    applyStimulus(0, 1, 8'hF0, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 3'd1, 3'd5, 0);
    checkOutput("abort busy1", busy, 1);
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
    checkOutput("abort step1 dout", dout, 8'h78);
    checkOutput("abort busy2", busy, 1);
    applyStimulus(0, 1, 8'h55, 0, 0, 0, 0);
    checkOutput("abort dout", dout, 8'h55);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort ser_out", ser_out, 0);
    dc = 0;
    if (done) dc++;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
      if (done) dc++;
    end
    checkOutput("abort done count", dc, 0);
    checkOutput("abort dout hold", dout, 8'h55);

    // Second start on the first busy cycle must be ignored.
    applyStimulus(0, 1, 8'h96, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 3'd2, 3'd3, 0);
    applyStimulus(0, 1'b0, 8'hAA, 1, 3'd0, 3'd7, 1);
    start = 0;
    bc = 1; dc = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) bc++;
      if (done) begin
        dc++;
        checkOutput("restart done timing", bc, 3);
        checkOutput("restart dout", dout, 8'hF2);
        checkOutput("restart ser_out", ser_out, 1);
      end
      applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
    end
    checkOutput("restart busy cycles", bc, 3);
    checkOutput("restart done count", dc, 1);

    // Reset mid-operation discards it silently.
    applyStimulus(0, 1, 8'h3C, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 3'd3, 3'd6, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 0, 0, 0);
    checkOutput("midrst dout", dout, 0);
    checkOutput("midrst busy", busy, 0);
    dc = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
      if (done) dc++;
    end
    checkOutput("midrst done count", dc, 0);

    // Random traffic against a cycle-level reference model.
    m_dout = 0; m_so = 0; m_busy = 0; m_done = 0; m_cnt = 0; m_mode = 0;
    for (int c = 0; c < 300; c++) begin
      r   = ($urandom_range(0, 49) == 0);
      ld  = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 2) == 0);
      d   = 8'($urandom);
      md  = 3'($urandom_range(0, 7));
      amt = 3'($urandom_range(0, 7));
      si  = 1'($urandom);
      if (r) begin
        m_dout = 0; m_so = 0; m_busy = 0; m_done = 0; m_cnt = 0; m_mode = 0;
      end else if (ld) begin
        m_dout = d; m_so = 0; m_busy = 0; m_cnt = 0; m_done = 0;
      end else if (!m_busy) begin
        m_done = st && (amt == 0);
        if (st && amt != 0) begin
          m_busy = 1; m_cnt = amt; m_mode = md;
        end
      end else begin
        st9 = model_step(m_dout, m_mode, si, m_so);
        m_so = st9[8];
        m_dout = st9[7:0];
        m_cnt = m_cnt - 1;
        m_done = (m_cnt == 0);
        if (m_cnt == 0) m_busy = 0;
      end
      applyStimulus(r, ld, d, st, md, amt, si);
      checkOutput($sformatf("rand%0d dout", c), dout, m_dout);
      checkOutput($sformatf("rand%0d ser_out", c), ser_out, m_so);
      checkOutput($sformatf("rand%0d busy", c), busy, m_busy);
      checkOutput($sformatf("rand%0d done", c), done, m_done);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
